// File: rtl/mdu_iter.sv
// Multi-cycle HI/LO multiply/divide unit: result latched at start, committed after MULT_LAT/DIV_LAT cycles.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) enabled by defining MDU_MADD_EN.
module mdu_iter #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] temp_hi_q, temp_hi_d;
  logic [31:0] temp_lo_q, temp_lo_d;
  logic [31:0] hi_d, lo_d;
  logic        busy_d;

  logic        mul_op;
  logic        div_op;
  logic [63:0] rs_sx, rt_sx;
  logic [63:0] prod_s, prod_u;
  logic [63:0] mul_res;
  logic signed [31:0] rs_sg, rt_sg;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic [63:0] div_res;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign rs_sx  = {{32{rs_val[31]}}, rs_val};
  assign rt_sx  = {{32{rt_val[31]}}, rt_val};
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};
  assign rs_sg  = $signed(rs_val);
  assign rt_sg  = $signed(rt_val);

`ifdef MDU_MADD_EN
  assign mul_op = (op == OP_MULT) || (op == OP_MULTU) ||
                  ((op >= OP_MADD) && (op <= OP_MSUBU));
`else
  assign mul_op = (op == OP_MULT) || (op == OP_MULTU);
`endif
  assign div_op = (op == OP_DIV) || (op == OP_DIVU);

  always_comb begin
    mul_res = prod_s;
    case (op)
      OP_MULTU: mul_res = prod_u;
`ifdef MDU_MADD_EN
      OP_MADD:  mul_res = {hi, lo} + prod_s;
      OP_MADDU: mul_res = {hi, lo} + prod_u;
      OP_MSUB:  mul_res = {hi, lo} - prod_s;
      OP_MSUBU: mul_res = {hi, lo} - prod_u;
`endif
      default:  mul_res = prod_s;
    endcase
  end

  // Zero divisor and the single signed overflow case are resolved explicitly.
  always_comb begin
    quo_s = 32'd0;
    rem_s = 32'd0;
    quo_u = 32'd0;
    rem_u = 32'd0;
    if (rt_val != 32'd0) begin
      quo_u = rs_val / rt_val;
      rem_u = rs_val % rt_val;
      if ((rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF)) begin
        quo_s = 32'h8000_0000;
        rem_s = 32'd0;
      end else begin
        quo_s = $unsigned(rs_sg / rt_sg);
        rem_s = $unsigned(rs_sg % rt_sg);
      end
    end
  end

  always_comb begin
    if (rt_val == 32'd0)
      div_res = {hi, lo};
    else if (op == OP_DIV)
      div_res = {rem_s, quo_s};
    else
      div_res = {rem_u, quo_u};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    hi_d      = hi;
    lo_d      = lo;
    busy_d    = busy;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (mul_op) begin
            {temp_hi_d, temp_lo_d} = mul_res;
            cnt_d   = MULT_CNT;
            state_d = RUN;
            busy_d  = 1'b1;
          end else if (div_op) begin
            {temp_hi_d, temp_lo_d} = div_res;
            cnt_d   = DIV_CNT;
            state_d = RUN;
            busy_d  = 1'b1;
          end else if (op == OP_MTHI) begin
            hi_d = rs_val;
          end else if (op == OP_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      RUN: begin
        // Any start while running is dropped; the EX stage stalls on busy.
        if (cnt_q == 4'd0) begin
          hi_d    = temp_hi_q;
          lo_d    = temp_lo_q;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      temp_hi_q <= 32'd0;
      temp_lo_q <= 32'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      hi        <= hi_d;
      lo        <= lo_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port start  input  1  single-cycle request from EX stage; sampled at rising edge.
REQ-004 SHALL have port op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; others none.
REQ-005 SHALL have port rs_val  input  32  forwarded GPR[rs] operand.
REQ-006 SHALL have port rt_val  input  32  forwarded GPR[rt] operand.
REQ-007 SHALL have port busy  output  1  registered; high while an operation is in flight.
REQ-008 SHALL have port hi  output  32  architectural HI register.
REQ-009 SHALL have port lo  output  32  architectural LO register.
REQ-010 SHALL have parameter MULT_LAT, default 5, busy cycles for multiply-class ops.
REQ-011 SHALL have parameter DIV_LAT, default 10, busy cycles for divide ops.

Function
REQ-012 SHALL implement two states: IDLE (busy=0) and RUN (busy=1) with a 4-bit down-counter.
REQ-013 IDLE, start=1, op in {1,2,7..10}: latch result into temp_hi/temp_lo, load counter MULT_LAT-1, go RUN.
REQ-014 IDLE, start=1, op in {3,4}: latch quotient/remainder into temp regs, load counter DIV_LAT-1, go RUN.
REQ-015 RUN: counter decrements each edge; at the edge where counter is 0, hi/lo <= temp, busy drops, go IDLE.
REQ-016 SHALL hold busy high for exactly MULT_LAT (DIV_LAT) cycles following the sampling edge.
REQ-017 mult: {hi,lo} = signed rs_val*rt_val, 64-bit; multu unsigned.
REQ-018 div: lo = signed quotient truncated toward zero, hi = remainder with sign of dividend; divu unsigned.
REQ-019 Divisor 0: SHALL still run DIV_LAT cycles; hi/lo SHALL keep previous values at commit.
REQ-020 div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0; no trap.
REQ-021 madd/maddu: {hi,lo} += product; msub/msubu: {hi,lo} -= product; 64-bit wrap, HI/LO value taken at start edge.
REQ-022 mthi/mtlo in IDLE with start=1: write rs_val to hi/lo at that edge, busy stays 0.
REQ-023 start while RUN (any op, including mthi/mtlo) SHALL be ignored; EX stalls on busy.
REQ-024 start with op 0 or undefined SHALL have no effect.
REQ-025 hi/lo SHALL change only at commit edge, mthi/mtlo edge, or reset; reads during RUN return old values.

Reset
REQ-026 reset SHALL force state IDLE, counter 0, busy 0, hi 0, lo 0, temp regs 0, aborting any in-flight op without commit.
REQ-027 start coincident with reset deassertion edge SHALL be sampled normally on the next edge only.

Configuration
REQ-028 Macro MDU_MADD_EN: defined, ops 7..10 behave per REQ-021.
REQ-029 Without MDU_MADD_EN, ops 7..10 SHALL be treated as none (no busy, no HI/LO change).

Verification
REQ-030 mult 0xFFFFFFFF x 0x00000002 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu same -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-031 div 0xFFFFFFF9 (-7) / 2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 -> hi/lo unchanged after 10 cycles.
REQ-032 mthi 0x12345678 in IDLE -> hi=0x12345678 next edge, busy never asserts; mtlo during RUN -> lo unchanged.
REQ-033 reset asserted 3 cycles into a div -> busy=0, hi=lo=0 immediately; no later commit.
REQ-034 MDU_MADD_EN defined, hi=0, lo=0xFFFFFFFF, madd 1x1 -> hi=1, lo=0 after 5 cycles; undefined -> no change, busy 0.
REQ-035 start mult while RUN from prior div -> only div result commits; hi/lo change exactly once.
